// File: rtl/fx_pkg.sv
// fx_pkg: shared definitions for the fx_seq seven-segment effect sequencer.
//   - segment-bit constants (bit 0 = a ... bit 6 = g, active-high)
//   - pattern-index and frame-index types
//   - FX_TABLE: 16 patterns x 8 frames x 7 segment bits
//   - fx_auto_next(): pattern auto-cycle successor (skips the blank pattern 15)
package fx_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_A   = 7'h01;
  localparam logic [6:0] SEG_B   = 7'h02;
  localparam logic [6:0] SEG_C   = 7'h04;
  localparam logic [6:0] SEG_D   = 7'h08;
  localparam logic [6:0] SEG_E   = 7'h10;
  localparam logic [6:0] SEG_F   = 7'h20;
  localparam logic [6:0] SEG_G   = 7'h40;
  localparam logic [6:0] SEG_ALL = 7'h7f;

  typedef logic [3:0] pat_idx_t;
  typedef logic [2:0] frame_t;

  localparam pat_idx_t PAT_BLANK = 4'd15;

  localparam logic [6:0] FX_TABLE [16][8] = '{
    // 0: single-segment chase around the outer ring
    '{SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_A, SEG_B},
    // 1: reverse chase
    '{SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_F, SEG_E},
    // 2: full blink
    '{SEG_ALL, SEG_OFF, SEG_ALL, SEG_OFF, SEG_ALL, SEG_OFF, SEG_ALL, SEG_OFF},
    // 3: vertical bounce a-g-d-g
    '{SEG_A, SEG_G, SEG_D, SEG_G, SEG_A, SEG_G, SEG_D, SEG_G},
    // 4: two-segment chase
    '{7'h03, 7'h06, 7'h0c, 7'h18, 7'h30, 7'h21, 7'h03, 7'h06},
    // 5: fill
    '{7'h01, 7'h03, 7'h07, 7'h0f, 7'h1f, 7'h3f, 7'h7f, 7'h00},
    // 6: drain
    '{7'h7f, 7'h3f, 7'h1f, 7'h0f, 7'h07, 7'h03, 7'h01, 7'h00},
    // 7: alternating halves
    '{7'h09, 7'h36, 7'h09, 7'h36, 7'h09, 7'h36, 7'h09, 7'h36},
    // 8: centre-bar blink
    '{SEG_G, SEG_OFF, SEG_G, SEG_OFF, SEG_G, SEG_OFF, SEG_G, SEG_OFF},
    // 9: left/right swap
    '{7'h06, 7'h30, 7'h06, 7'h30, 7'h06, 7'h30, 7'h06, 7'h30},
    // 10: spiral build
    '{7'h01, 7'h21, 7'h31, 7'h39, 7'h3d, 7'h3f, 7'h7f, 7'h40},
    // 11: bottom-up build
    '{7'h08, 7'h0c, 7'h0e, 7'h0f, 7'h2f, 7'h3f, 7'h7f, 7'h00},
    // 12: horizontal/vertical flash
    '{7'h49, 7'h00, 7'h49, 7'h00, 7'h36, 7'h00, 7'h36, 7'h00},
    // 13: count 0..7
    '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07},
    // 14: letters A b C d E F G H
    '{7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71, 7'h3d, 7'h76},
    // 15: blank
    '{SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF}
  };

  // Pattern 15 is blank, so auto-cycling steps 13 -> 14 -> 0.
  function automatic pat_idx_t fx_auto_next(pat_idx_t p);
    return (p >= 4'd14) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

// File: rtl/fx_rom.sv
// fx_rom: combinational pattern-table lookup, one instance per digit.
//   pattern [3:0]  in   pattern index
//   frame   [2:0]  in   frame index (already offset for the digit)
//   seg     [6:0]  out  segment bits, bit 0 = a ... bit 6 = g
module fx_rom
  import fx_pkg::*;
(
  input  logic [3:0] pattern,
  input  logic [2:0] frame,
  output logic [6:0] seg
);

  assign seg = FX_TABLE[pattern][frame];

endmodule

// File: rtl/fx_seq.sv
// fx_seq: seven-segment effect sequencer.
// A prescaler produces a frame tick every i_speed+1 cycles; each tick steps an 8-frame
// animation of the active pattern. Each digit shows the frame offset by d*PHASE.
// Pattern changes are requested with i_load and take effect on the next tick.
// Optional feature: define FX_AUTOCYCLE_EN to let i_auto advance the pattern on each wrap.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_speed   [PRESCALE_W-1:0] divider terminal value
//   i_sel     [3:0]  requested pattern; i_load strobe captures it
//   i_hold    freeze frame advance; i_auto auto-cycle enable
//   o_segment [7*N_DIGITS-1:0] registered segments, digit d at [7d+6:7d]
//   o_pattern [3:0] active pattern, o_frame [2:0] base frame
//   o_tick    pulse per divider terminal count, o_wrap pulse on frame 7->0
module fx_seq
  import fx_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned PRESCALE_W = 24,
  parameter int unsigned PHASE      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PRESCALE_W-1:0]   i_speed,
  input  logic [3:0]              i_sel,
  input  logic                    i_load,
  input  logic                    i_hold,
  input  logic                    i_auto,
  output logic [7*N_DIGITS-1:0]   o_segment,
  output logic [3:0]              o_pattern,
  output logic [2:0]              o_frame,
  output logic                    o_tick,
  output logic                    o_wrap
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic                  term;
  logic                  tick_q;
  logic                  wrap_q, wrap_d;
  frame_t                frame_q, frame_d;
  pat_idx_t              pat_q, pat_d;
  pat_idx_t              pend_pat_q, pend_pat_d;
  logic                  pend_q, pend_d;
  logic [7*N_DIGITS-1:0] seg_d, seg_q;

  // >= so that lowering i_speed below the running count terminates immediately.
  assign term = (cnt_q >= i_speed);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= term;
      cnt_q  <= term ? '0 : cnt_q + 1'b1;
    end
  end

`ifndef FX_AUTOCYCLE_EN
  logic unused_auto;
  assign unused_auto = i_auto;
`endif

  always_comb begin
    frame_d    = frame_q;
    pat_d      = pat_q;
    pend_d     = pend_q;
    pend_pat_d = pend_pat_q;
    wrap_d     = 1'b0;
    if (term) begin
      if (pend_q) begin
        // Pattern switch restarts the animation and overrides i_hold; not a wrap.
        pat_d   = pend_pat_q;
        frame_d = '0;
        pend_d  = 1'b0;
      end else if (!i_hold) begin
        frame_d = frame_q + 3'd1;
        if (frame_q == 3'd7) begin
          wrap_d = 1'b1;
`ifdef FX_AUTOCYCLE_EN
          if (i_auto) begin
            pat_d = fx_auto_next(pat_q);
          end
`endif
        end
      end
    end
    // A load on a tick edge is only captured; it is applied at the following tick.
    if (i_load) begin
      pend_d     = 1'b1;
      pend_pat_d = i_sel;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_q    <= '0;
      pat_q      <= '0;
      pend_q     <= 1'b0;
      pend_pat_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      pat_q      <= pat_d;
      pend_q     <= pend_d;
      pend_pat_q <= pend_pat_d;
      wrap_q     <= wrap_d;
    end
  end

  for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
    localparam logic [2:0] Offset = 3'((d * PHASE) % 8);
    logic [2:0] idx;
    assign idx = frame_q + Offset;
    fx_rom u_rom (
      .pattern (pat_q),
      .frame   (idx),
      .seg     (seg_d[7*d +: 7])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_q <= '0;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign o_segment = seg_q;
  assign o_pattern = pat_q;
  assign o_frame   = frame_q;
  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;

endmodule
